// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM encoding for the cache-to-memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic              valid_o
);

  always_comb begin : rrSelect
    int sum;
    logic [PTR_W-1:0] idx;
    gnt_o   = '0;
    valid_o = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = PTR_W'(sum);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slow memory port between NUM_CH cache channels, one
// transaction at a time, with round-robin fairness.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_CH);

  arb_state_e          state_q;
  logic                armed_q;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    grantIdx_q;
  logic [NUM_CH-1:0]   grant_q;
  logic                busy_q;
  logic                memRead_q, memWrite_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [LINE_W-1:0]   memWdata_q;
  logic [NUM_CH-1:0]   chReady_q;
  logic [LINE_W-1:0]   chRdata_q;

  logic [NUM_CH-1:0]   selGnt;
  logic                selValid;
  logic [PTR_W-1:0]    selIdx;
  logic [ADDR_W-1:0]   selAddr;
  logic [LINE_W-1:0]   selWdata;
  logic                selWrite;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) uRr (
    .req_i   (ch_read | ch_write),
    .ptr_i   (ptr_q),
    .gnt_o   (selGnt),
    .valid_o (selValid)
  );

  // Write wins when a channel raises both request lines.
  always_comb begin
    selIdx   = '0;
    selAddr  = '0;
    selWdata = '0;
    selWrite = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (selGnt[i]) begin
        selIdx   = PTR_W'(i);
        selAddr  = ch_addr[i*ADDR_W +: ADDR_W];
        selWdata = ch_wdata[i*LINE_W +: LINE_W];
        selWrite = ch_write[i];
      end
    end
  end

  assign ptr_d = (grantIdx_q == PTR_W'(NUM_CH - 1)) ? '0 : grantIdx_q + PTR_W'(1);

  // armed_q keeps the first edge after reset release request-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      ptr_q      <= '0;
      grantIdx_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      chReady_q  <= '0;
      chRdata_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (armed_q && selValid) begin
            grant_q    <= selGnt;
            grantIdx_q <= selIdx;
            memAddr_q  <= selAddr;
            memWdata_q <= selWdata;
            memWrite_q <= selWrite;
            memRead_q  <= !selWrite;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            if (memRead_q) chRdata_q <= mem_rdata;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            chReady_q  <= grant_q;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          chReady_q <= '0;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          ptr_q     <= ptr_d;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_rdata  = chRdata_q;
  assign ch_ready  = chReady_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: channel driver pushes expectations, a negedge monitor
// plays the slow memory and checks every memory request and completion.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef struct { logic rd; logic wr; addr_t addr; line_t wdata; int gap; } req_t;
  typedef struct { logic isWr; addr_t addr; line_t wdata; line_t rdata; } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        chRead, chWrite;
  logic [NUM_CH*ADDR_W-1:0] chAddr;
  logic [NUM_CH*LINE_W-1:0] chWdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_ready, grant;
  logic                     mem_read, mem_write, busy;
  logic [ADDR_W-1:0]        mem_addr;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        memRdata = '0;
  logic                     memReady = 1'b0;

  req_t  script[NUM_CH][$];
  exp_t  expQ[NUM_CH][$];
  line_t memArr[addr_t];
  line_t refMem[addr_t];
  int    checks = 0;
  int    errors = 0;
  int    fixedLat = 0;

  int                ptrModel = 0;
  logic [NUM_CH-1:0] prevReq = '0, prevReady = '0;
  logic              prevMem = 1'b0, inTx = 1'b0, txWr = 1'b0;
  line_t             lastRdata = '0, txWdata = '0;
  addr_t             txAddr = '0;
  int                memCycles = 0, txCnt = 0, txLat = 1, lastLat = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_read   (chRead),
    .ch_write  (chWrite),
    .ch_addr   (chAddr),
    .ch_wdata  (chWdata),
    .ch_rdata  (ch_rdata),
    .ch_ready  (ch_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (memRdata),
    .mem_ready (memReady),
    .grant     (grant),
    .busy      (busy)
  );

  function automatic line_t defLine(addr_t a);
    return {(LINE_W/32){32'(a) ^ 32'hC0DE_0000}};
  endfunction

  function automatic line_t randLine();
    line_t l;
    for (int k = 0; k < LINE_W/32; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic req_t mkReq(logic rd, logic wr, addr_t a, line_t d, int gap);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d; r.gap = gap;
    return r;
  endfunction

  // Round-robin rule: first requester scanning upward from the pointer.
  function automatic logic [NUM_CH-1:0] rrPick(logic [NUM_CH-1:0] req, int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (ptr + k) % NUM_CH;
      if (req[c]) return NUM_CH'(1) << c;
    end
    return '0;
  endfunction

  function automatic int oneHotIdx(logic [NUM_CH-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int k = 0; k < NUM_CH; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issueReq(input int ch, input req_t r);
    exp_t e;
    chRead[ch]  = r.rd;
    chWrite[ch] = r.wr;
    chAddr[ch*ADDR_W +: ADDR_W]  = r.addr;
    chWdata[ch*LINE_W +: LINE_W] = r.wdata;
    e.isWr  = r.wr;
    e.addr  = r.addr;
    e.wdata = r.wdata;
    e.rdata = '0;
    if (r.wr) refMem[r.addr] = r.wdata;
    else e.rdata = refMem.exists(r.addr) ? refMem[r.addr] : defLine(r.addr);
    expQ[ch].push_back(e);
  endtask

  // Runs every channel's script: hold each request until its ch_ready,
  // scramble addr/wdata while being served, then wait the scripted gap.
  task automatic applyStimulus(input int maxCycles);
    logic              active[NUM_CH];
    int                gapCnt[NUM_CH];
    logic [NUM_CH-1:0] sawReady, sawGrant;
    bit                allDone;
    int                cyc;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = 1'b0;
      gapCnt[i] = (script[i].size() > 0) ? script[i][0].gap : 0;
    end
    allDone = 1'b0;
    cyc = 0;
    while (!allDone && cyc < maxCycles) begin
      @(negedge clk);
      sawReady = ch_ready;
      sawGrant = grant;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (active[i] && sawReady[i]) begin
          active[i]  = 1'b0;
          chRead[i]  = 1'b0;
          chWrite[i] = 1'b0;
          if (script[i].size() > 0) gapCnt[i] = script[i][0].gap;
        end else if (active[i] && sawGrant[i]) begin
          chAddr[i*ADDR_W +: ADDR_W]  = addr_t'($urandom());
          chWdata[i*LINE_W +: LINE_W] = randLine();
        end
        if (!active[i] && script[i].size() > 0) begin
          if (gapCnt[i] == 0) begin
            issueReq(i, script[i].pop_front());
            active[i] = 1'b1;
          end else begin
            gapCnt[i]--;
          end
        end
      end
      allDone = 1'b1;
      for (int i = 0; i < NUM_CH; i++) if (active[i] || script[i].size() > 0) allDone = 1'b0;
    end
    checks++;
    if (!allDone) begin
      errors++;
      $display("[TB] FAIL stimulus_timeout: traffic still pending after %0d cycles, expected drained", maxCycles);
      for (int i = 0; i < NUM_CH; i++) script[i].delete();
    end
  endtask

  // Monitor and slow-memory model on the falling edge.
  always @(negedge clk) begin : monitor
    int                idx;
    exp_t              e;
    logic [NUM_CH-1:0] expG;
    logic              memAct;
    if (!rst_n) begin
      ptrModel  = 0;
      prevReq   = '0;
      prevReady = '0;
      prevMem   = 1'b0;
      lastRdata = '0;
      inTx      = 1'b0;
      memReady  = 1'b0;
      memCycles = 0;
    end else begin
      memAct = mem_read | mem_write;
      if (memAct && !prevMem) begin
        expG = rrPick(prevReq, ptrModel);
        checkOutput("rr_grant", grant, expG);
        idx = oneHotIdx(grant);
        if (idx >= 0 && expQ[idx].size() > 0) begin
          e = expQ[idx][0];
          checkOutput("mem_dir", {mem_read, mem_write}, {!e.isWr, e.isWr});
          checkOutput("mem_addr", mem_addr, e.addr);
          if (e.isWr) checkOutput("mem_wdata", mem_wdata, e.wdata);
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_start: grant %b has no pending request, expected %b", grant, expG);
        end
        memCycles = 0;
      end
      if (memAct) memCycles++;

      if (ch_ready != '0) begin
        idx = oneHotIdx(ch_ready);
        checkOutput("ready_matches_grant", ch_ready, grant);
        checkOutput("ready_single_pulse", prevReady, '0);
        checkOutput("mem_cycles", memCycles, lastLat);
        if (idx >= 0 && expQ[idx].size() > 0) begin
          e = expQ[idx].pop_front();
          if (e.isWr) checkOutput("rdata_hold_on_write", ch_rdata, lastRdata);
          else        checkOutput("ch_rdata", ch_rdata, e.rdata);
          ptrModel = (idx + 1) % NUM_CH;
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL ready_unexpected: ch_ready %b, expected no completion", ch_ready);
        end
        lastRdata = ch_rdata;
      end else begin
        checkOutput("rdata_hold", ch_rdata, lastRdata);
      end
      checkOutput("busy", busy, grant != '0);

      if (memAct) begin
        if (!inTx) begin
          inTx    = 1'b1;
          txCnt   = 0;
          txLat   = (fixedLat > 0) ? fixedLat : $urandom_range(1, 6);
          lastLat = txLat;
          txAddr  = mem_addr;
          txWr    = mem_write;
          txWdata = mem_wdata;
        end
        txCnt++;
        checkOutput("mem_hold", {mem_read, mem_write, mem_addr}, {!txWr, txWr, txAddr});
        checkOutput("mem_wdata_hold", mem_wdata, txWdata);
        memRdata = randLine();
        if (txCnt == txLat) begin
          memReady = 1'b1;
          if (txWr) memArr[txAddr] = txWdata;
          else memRdata = memArr.exists(txAddr) ? memArr[txAddr] : defLine(txAddr);
          inTx = 1'b0;
        end else begin
          memReady = 1'b0;
        end
      end else begin
        memReady = 1'($urandom_range(0, 1));
        memRdata = randLine();
      end
      prevReq   = chRead | chWrite;
      prevMem   = memAct;
      prevReady = ch_ready;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    addr_t rA;
    int    n, cyc;
    rst_n   = 1'b0;
    chRead  = '0;
    chWrite = '0;
    chAddr  = '0;
    chWdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ch_ready", ch_ready, '0);
    checkOutput("reset_ch_rdata", ch_rdata, '0);
    checkOutput("reset_grant", grant, '0);
    checkOutput("reset_busy", busy, '0);
    checkOutput("reset_mem_rw", {mem_read, mem_write}, '0);
    checkOutput("reset_mem_addr", mem_addr, '0);
    checkOutput("reset_mem_wdata", mem_wdata, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Simultaneous reads right after reset: ch0 then ch1.
    script[0].push_back(mkReq(1'b1, 1'b0, 28'h0000003, '0, 0));
    script[1].push_back(mkReq(1'b1, 1'b0, 28'h0100002, '0, 0));
    applyStimulus(300);

    // ch0 read of a preloaded line with a five-cycle memory.
    memArr[28'h0000010] = {16{8'hA5}};
    refMem[28'h0000010] = {16{8'hA5}};
    fixedLat = 5;
    script[0].push_back(mkReq(1'b1, 1'b0, 28'h0000010, '0, 0));
    applyStimulus(100);
    fixedLat = 0;

    script[1].push_back(mkReq(1'b0, 1'b1, 28'h0000020, {4{32'h12345678}}, 0));
    applyStimulus(100);

    // Read+write together is a write; read it back afterwards.
    script[2].push_back(mkReq(1'b1, 1'b1, 28'h0200001, randLine(), 0));
    script[2].push_back(mkReq(1'b1, 1'b0, 28'h0200001, '0, 1));
    applyStimulus(200);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NUM_CH; i++)
        script[i].push_back(mkReq(1'b1, 1'b0, (addr_t'(i) << 20) | addr_t'(r), '0, 0));
    applyStimulus(1000);

    for (int i = 0; i < NUM_CH; i++) begin
      for (int r = 0; r < 30; r++) begin
        int kind = $urandom_range(0, 3);
        script[i].push_back(mkReq(kind != 2, kind >= 2,
                                  (addr_t'(i) << 20) | addr_t'($urandom_range(0, 7)),
                                  randLine(), $urandom_range(0, 4)));
      end
    end
    applyStimulus(20000);

    // Reset in the third ISSUE cycle of a ch1 read, then re-serve it.
    fixedLat = 10;
    rA = 28'h0100005;
    @(posedge clk);
    #1;
    issueReq(1, mkReq(1'b1, 1'b0, rA, '0, 0));
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_read) n++;
    end
    checkOutput("rst_reach_issue", n, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ch_ready", ch_ready, '0);
    checkOutput("midrst_ch_rdata", ch_rdata, '0);
    checkOutput("midrst_grant", grant, '0);
    checkOutput("midrst_busy", busy, '0);
    checkOutput("midrst_mem_rw", {mem_read, mem_write}, '0);
    checkOutput("midrst_mem_addr", mem_addr, '0);
    checkOutput("midrst_mem_wdata", mem_wdata, '0);
    fixedLat = 0;
    expQ[1].delete();
    issueReq(1, mkReq(1'b1, 1'b0, rA, '0, 0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("no_req_first_edge", {busy, mem_read, mem_write}, '0);
    cyc = 0;
    while (!ch_ready[1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_reserve_ready", ch_ready[1], 1'b1);
    @(posedge clk);
    #1;
    chRead[1] = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < NUM_CH; i++) checkOutput("scoreboard_drain", expQ[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
